adder_meas_sequencer: RTL and testbench

- Initiator side of the instrumented-adder measurement interface.
- Accepts a measurement command over a valid/ready port: operands a and b plus a gate window length.
- Drives the operands to the adder and enables the ring/chain for exactly the window, counting rising edges of the adder's chain_out.
- Returns the edge count and the sampled sum over a valid/ready response port. Sits between the logic-analyzer/wishbone control glue and the wrapped adder.

---
 rtl/adder_meas_pkg.sv | 18 +
 rtl/meas_edge_counter.sv | 47 ++++
 rtl/adder_meas_sequencer.sv | 173 +++++++++++++++++
 tb/tb_adder_meas_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_meas_pkg.sv
// Shared types and defaults for the instrumented-adder measurement sequencer.
package adder_meas_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_CNT_W    = 32;
  localparam int DEF_WIN_W    = 16;
  localparam int DEF_SETTLE   = 4;
  localparam int DRAIN_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } meas_state_t;

endpackage

// File: rtl/meas_edge_counter.sv
// Synchronizes the asynchronous chain output, detects rising edges and counts
// them while enabled, saturating at all-ones.
module meas_edge_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             async_in,
  output logic [CNT_W-1:0] count
);

  logic             sync1_r;
  logic             sync2_r;
  logic             prev_r;
  logic             edge_s;
  logic [CNT_W-1:0] count_r;

  assign edge_s = sync2_r & ~prev_r;
  assign count  = count_r;

  // two-flop synchronizer plus previous-value flop; runs in every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
    end else begin
      sync1_r <= async_in;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // saturating edge counter with synchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && edge_s && (count_r != {CNT_W{1'b1}})) begin
      count_r <= count_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/adder_meas_sequencer.sv
// Measurement initiator for the instrumented adder: settle, gated ring window,
// drain, then response. Define ADDER_MEAS_SUM_CHECK_EN to add the rsp_err sum check.
module adder_meas_sequencer
  import adder_meas_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int WIN_W  = DEF_WIN_W,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [WIN_W-1:0]  cmd_window,
  output logic [DATA_W-1:0] adder_a,
  output logic [DATA_W-1:0] adder_b,
  output logic              ring_en,
  input  logic [DATA_W-1:0] adder_sum,
  input  logic              chain_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [CNT_W-1:0]  rsp_count,
  output logic [DATA_W-1:0] rsp_sum,
  output logic              busy
`ifdef ADDER_MEAS_SUM_CHECK_EN
  ,
  output logic              rsp_err
`endif
);

  localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(SETTLE - 1);
  localparam logic [WIN_W-1:0] DRAIN_LAST  = WIN_W'(DRAIN_CYCLES - 1);

  meas_state_t       state_r;
  meas_state_t       next_state_s;
  logic [WIN_W-1:0]  phase_r;
  logic [WIN_W-1:0]  phase_nxt_s;
  logic [WIN_W-1:0]  window_r;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic [DATA_W-1:0] sum_r;
  logic              cmd_ready_r;
  logic              ring_en_r;
  logic              busy_r;
  logic              rsp_valid_r;
  logic              accept_s;
  logic              rsp_hs_s;
  logic              last_load_s;

  assign accept_s    = cmd_valid & cmd_ready_r;
  assign rsp_hs_s    = rsp_valid_r & rsp_ready;
  assign last_load_s = (state_r == ST_LOAD) && (phase_r == SETTLE_LAST);

  assign cmd_ready = cmd_ready_r;
  assign adder_a   = a_r;
  assign adder_b   = b_r;
  assign ring_en   = ring_en_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_sum   = sum_r;
  assign busy      = busy_r;

  // next-state and phase-counter logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) next_state_s = ST_LOAD;
        else          next_state_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (phase_r == SETTLE_LAST) next_state_s = (window_r != '0) ? ST_RUN : ST_DRAIN;
        else                        next_state_s = ST_LOAD;
      end
      ST_RUN: begin
        if (phase_r == (window_r - WIN_W'(1))) next_state_s = ST_DRAIN;
        else                                   next_state_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (phase_r == DRAIN_LAST) next_state_s = ST_DONE;
        else                       next_state_s = ST_DRAIN;
      end
      ST_DONE: begin
        if (rsp_hs_s) next_state_s = ST_IDLE;
        else          next_state_s = ST_DONE;
      end
      default: next_state_s = ST_IDLE;
    endcase

    phase_nxt_s = phase_r + WIN_W'(1);
    if ((next_state_s != state_r) || (state_r == ST_IDLE) || (state_r == ST_DONE)) begin
      phase_nxt_s = '0;
    end else begin
      phase_nxt_s = phase_r + WIN_W'(1);
    end
  end

  // state register and registered handshake/control outputs
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_r     <= ST_IDLE;
      phase_r     <= '0;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      ring_en_r   <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      phase_r     <= phase_nxt_s;
      cmd_ready_r <= (next_state_s == ST_IDLE);
      busy_r      <= (next_state_s != ST_IDLE);
      ring_en_r   <= (next_state_s == ST_RUN);
      // response is presented one cycle after DONE entry and drops on the handshake
      rsp_valid_r <= (state_r == ST_DONE) && !rsp_hs_s;
    end
  end

  // command latch and sum capture; operands hold their value between measurements
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      a_r      <= '0;
      b_r      <= '0;
      window_r <= '0;
      sum_r    <= '0;
    end else begin
      if (accept_s) begin
        a_r      <= cmd_a;
        b_r      <= cmd_b;
        window_r <= cmd_window;
      end
      if (last_load_s) begin
        sum_r <= adder_sum;
      end
    end
  end

  meas_edge_counter #(
    .CNT_W (CNT_W)
  ) u_edge_counter (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_n_i),
    .clear    (accept_s),
    .enable   (state_r == ST_RUN),
    .async_in (chain_out),
    .count    (rsp_count)
  );

`ifdef ADDER_MEAS_SUM_CHECK_EN
  logic err_r;

  function automatic logic sum_mismatch(input logic [DATA_W-1:0] a,
                                        input logic [DATA_W-1:0] b,
                                        input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] ref_sum;
    ref_sum = a + b;
    return ref_sum != s;
  endfunction

  // flags a sampled sum that disagrees with the modular reference
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      err_r <= 1'b0;
    end else if (last_load_s) begin
      err_r <= sum_mismatch(a_r, b_r, adder_sum);
    end
  end

  assign rsp_err = err_r;
`endif

endmodule

// File: tb/tb_adder_meas_sequencer.sv
// Scoreboard bench for adder_meas_sequencer with a stub adder and a toggling chain output.
module tb_adder_meas_sequencer;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int WW = 16;
  localparam int ST = 4;

  logic          wb_clk_i   = 1'b0;
  logic          wb_rst_n_i = 1'b0;
  logic          cmd_valid  = 1'b0;
  logic          cmd_ready;
  logic [DW-1:0] cmd_a      = '0;
  logic [DW-1:0] cmd_b      = '0;
  logic [WW-1:0] cmd_window = '0;
  logic [DW-1:0] adder_a;
  logic [DW-1:0] adder_b;
  logic          ring_en;
  logic [DW-1:0] adder_sum;
  logic          chain_out  = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready  = 1'b0;
  logic [CW-1:0] rsp_count;
  logic [DW-1:0] rsp_sum;
  logic          busy;
`ifdef ADDER_MEAS_SUM_CHECK_EN
  logic          rsp_err;
`endif

  int   n_cmp = 0;
  int   n_err = 0;
  int   bug = 0;
  logic chain_tgl = 1'b1;

  typedef struct {
    logic [CW-1:0] cnt;
    logic [DW-1:0] sum;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    int            lat;
    int            ring;
    logic          err;
  } exp_t;
  exp_t sb_q[$];

  // stub adder, optionally off by `bug`
  assign adder_sum = adder_a + adder_b + DW'(bug);

  adder_meas_sequencer #(
    .DATA_W (DW), .CNT_W (CW), .WIN_W (WW), .SETTLE (ST)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_n_i (wb_rst_n_i),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_window (cmd_window),
    .adder_a    (adder_a),
    .adder_b    (adder_b),
    .ring_en    (ring_en),
    .adder_sum  (adder_sum),
    .chain_out  (chain_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_count  (rsp_count),
    .rsp_sum    (rsp_sum),
    .busy       (busy)
`ifdef ADDER_MEAS_SUM_CHECK_EN
    ,
    .rsp_err    (rsp_err)
`endif
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // chain output toggles each cycle: one rising edge every two clocks
  always @(negedge wb_clk_i) begin
    if (chain_tgl) chain_out = ~chain_out;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_cmd(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [WW-1:0] w);
    @(negedge wb_clk_i);
    cmd_a      = a;
    cmd_b      = b;
    cmd_window = w;
    cmd_valid  = 1'b1;
  endtask

  // waits for acceptance, pushes the expected response, leaves time just after edge 0
  task automatic wait_accept();
    int   t;
    exp_t e;
    int   half;
    t = 0;
    while (!cmd_ready && t < 100) begin
      @(negedge wb_clk_i);
      t++;
    end
    chk("accept_in_time", 64'(t < 100), 64'd1);
    @(posedge wb_clk_i);
    half   = chain_tgl ? int'(cmd_window) / 2 : 0;
    e.cnt  = (half > 15) ? 4'hF : CW'(half);
    e.sum  = cmd_a + cmd_b + DW'(bug);
    e.a    = cmd_a;
    e.b    = cmd_b;
    e.lat  = ST + int'(cmd_window) + 3;
    e.ring = int'(cmd_window);
    e.err  = (bug != 0);
    sb_q.push_back(e);
    #1 cmd_valid = 1'b0;
  endtask

  // follows one measurement to its response, holds it for `hold` cycles, then consumes it
  task automatic get_rsp(input int hold);
    exp_t e;
    int   k;
    int   ring;
    chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
    if (sb_q.size() == 0) return;
    e    = sb_q.pop_front();
    k    = 0;
    ring = 0;
    while (k < 500) begin
      @(posedge wb_clk_i);
      #1;
      k++;
      if (ring_en) ring++;
      if (rsp_valid) break;
      chk("busy_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    chk("latency", 64'(k), 64'(e.lat));
    chk("ring_cycles", 64'(ring), 64'(e.ring));
    chk("count", 64'(rsp_count), 64'(e.cnt));
    chk("sum", 64'(rsp_sum), 64'(e.sum));
    chk("adder_a", 64'(adder_a), 64'(e.a));
    chk("adder_b", 64'(adder_b), 64'(e.b));
`ifdef ADDER_MEAS_SUM_CHECK_EN
    chk("err", 64'(rsp_err), 64'(e.err));
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge wb_clk_i);
      #1;
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_count", 64'(rsp_count), 64'(e.cnt));
      chk("hold_sum", 64'(rsp_sum), 64'(e.sum));
      chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge wb_clk_i);
    #1 rsp_ready = 1'b0;
    chk("rsp_drop", 64'(rsp_valid), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge wb_clk_i);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_ring_en", 64'(ring_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_count", 64'(rsp_count), 64'd0);
    chk("rst_adder_a", 64'(adder_a), 64'd0);
    wb_rst_n_i = 1'b1;

    // basic measurement
    drive_cmd(32'h0000_0005, 32'h0000_0003, 16'd10);
    wait_accept();
    get_rsp(0);
    repeat (3) @(negedge wb_clk_i);
    chk("idle_hold_a", 64'(adder_a), 64'h5);
    chk("idle_hold_b", 64'(adder_b), 64'h3);

    // zero window with rsp_ready held high beforehand
    rsp_ready = 1'b1;
    drive_cmd(32'hFFFF_FFFF, 32'h0000_0001, 16'd0);
    wait_accept();
    get_rsp(0);

    // saturation of the 4-bit counter
    drive_cmd(32'h0000_0007, 32'h0000_0009, 16'd100);
    wait_accept();
    get_rsp(0);

    // backpressure with a new command pending
    drive_cmd(32'h0000_1234, 32'h0000_0010, 16'd8);
    wait_accept();
    cmd_a      = 32'h0000_AAAA;
    cmd_b      = 32'h0000_5555;
    cmd_window = 16'd4;
    cmd_valid  = 1'b1;
    get_rsp(20);
    chk("accept_next", 64'(cmd_ready), 64'd1);
    wait_accept();
    get_rsp(0);

    // sum check: faulty then correct stub adder
    bug = 1;
    drive_cmd(32'h0000_0002, 32'h0000_0002, 16'd2);
    wait_accept();
    get_rsp(0);
    bug = 0;
    drive_cmd(32'h0000_0002, 32'h0000_0002, 16'd2);
    wait_accept();
    get_rsp(0);

    // reset during RUN
    drive_cmd(32'h0000_0011, 32'h0000_0022, 16'd50);
    wait_accept();
    repeat (10) @(posedge wb_clk_i);
    #2;
    chk("pre_rst_ring_en", 64'(ring_en), 64'd1);
    wb_rst_n_i = 1'b0;
    #1;
    chk("mid_rst_ring_en", 64'(ring_en), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_count", 64'(rsp_count), 64'd0);
    sb_q.delete();
    @(negedge wb_clk_i);
    wb_rst_n_i = 1'b1;
    drive_cmd(32'h0000_0100, 32'h0000_0200, 16'd6);
    wait_accept();
    get_rsp(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
